// File: rtl/multicycle_control_unit_if.sv
// Memory-side handshake bundle for the multi-cycle control unit.
// master: the control unit (issues requests, latches instr).
// slave: the instruction/data memory side.
interface multicycle_control_unit_if;
  logic [31:0] instr;
  logic        imem_req;
  logic        imem_ack;
  logic        ir_we;
  logic        dmem_req;
  logic        dmem_ack;
  logic        mem_we;

  modport master (
    input  instr, imem_ack, dmem_ack,
    output imem_req, ir_we, dmem_req, mem_we
  );

  modport slave (
    output instr, imem_ack, dmem_ack,
    input  imem_req, ir_we, dmem_req, mem_we
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB with
// req/ack memory handshakes, holds a registered control word for the whole
// instruction, traps on illegal encodings or ack timeouts, counts retires.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT   = 15,
  parameter int CHECK_ILLEGAL = 1,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_control_unit_if.master bus,
  output logic [2:0]               ExtOP,
  output logic                     RegWr,
  output logic [2:0]               Branch,
  output logic                     MemtoReg,
  output logic                     MemWr,
  output logic [2:0]               MemOP,
  output logic                     ALUAsrc,
  output logic [1:0]               ALUBsrc,
  output logic [3:0]               ALUctr,
  output logic                     reg_we,
  output logic                     pc_we,
  output logic [2:0]               state,
  output logic                     illegal,
  output logic                     timeout,
  output logic [CNT_W-1:0]         retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } st_e;

  typedef struct packed {
    logic [2:0] ext_op;
    logic       reg_wr;
    logic [2:0] branch;
    logic       mem_to_reg;
    logic       mem_wr;
    logic [2:0] mem_op;
    logic       alua_src;
    logic [1:0] alub_src;
    logic [3:0] alu_ctr;
  } cw_t;

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  st_e         st;
  cw_t         cw, dcw;
  logic        dill;
  logic [6:0]  ir_op;
  logic [2:0]  ir_f3;
  logic [6:0]  ir_f7;
  logic [TW-1:0] wcnt;
  logic        tmo_hit;
  logic        imem_req_q, dmem_req_q, mem_we_q, reg_we_q, pc_we_q;
  logic        is_op;

  // Register/immediate fields never influence control decisions.
  logic        unused_instr_bits;
  assign unused_instr_bits = ^{bus.instr[24:15], bus.instr[11:7]};

  // Last wait cycle with no ack: the ack, if present, still takes priority.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (int'(wcnt) == MEM_TIMEOUT - 1);
  assign is_op   = ir_op[5];

  // Combinational decode of the latched instruction fields into a control word.
  always_comb begin
    dcw  = '0;
    dill = 1'b0;
    if (ir_op[1:0] != 2'b11) begin
      dill = 1'b1;
    end else begin
      case (ir_op[6:2])
        5'b01101: begin // LUI
          dcw.ext_op   = 3'b001;
          dcw.reg_wr   = 1'b1;
          dcw.alub_src = 2'b01;
          dcw.alu_ctr  = 4'b0011;
        end
        5'b00101: begin // AUIPC
          dcw.ext_op   = 3'b001;
          dcw.reg_wr   = 1'b1;
          dcw.alua_src = 1'b1;
          dcw.alub_src = 2'b01;
        end
        5'b00100, 5'b01100: begin // OP-IMM / OP
          dcw.reg_wr       = 1'b1;
          dcw.alub_src     = is_op ? 2'b00 : 2'b01;
          dcw.alu_ctr[2:0] = (ir_f3 == 3'b011) ? 3'b010 : ir_f3;
          dcw.alu_ctr[3]   = (ir_f3 == 3'b011)
                           | ((ir_f3 == 3'b101) & ir_f7[5])
                           | (is_op & (ir_f3 == 3'b000) & ir_f7[5]);
          // func7 is only an opcode extension for OP and shift-immediates.
          if (is_op || ir_f3 == 3'b001 || ir_f3 == 3'b101) begin
            if (ir_f7 != 7'h00 && ir_f7 != 7'h20)
              dill = 1'b1;
            if (ir_f7[5] && !(ir_f3 == 3'b101 || (is_op && ir_f3 == 3'b000)))
              dill = 1'b1;
          end
        end
        5'b11011: begin // JAL
          dcw.ext_op   = 3'b100;
          dcw.reg_wr   = 1'b1;
          dcw.branch   = 3'b001;
          dcw.alua_src = 1'b1;
          dcw.alub_src = 2'b10;
        end
        5'b11001: begin // JALR
          dcw.reg_wr   = 1'b1;
          dcw.branch   = 3'b010;
          dcw.alua_src = 1'b1;
          dcw.alub_src = 2'b10;
          if (ir_f3 != 3'b000) dill = 1'b1;
        end
        5'b11000: begin // BRANCH
          dcw.ext_op  = 3'b011;
          dcw.branch  = {1'b1, ir_f3[2], ir_f3[0]};
          dcw.alu_ctr = ir_f3[1] ? 4'b1010 : 4'b0010;
          if (ir_f3[2:1] == 2'b01) dill = 1'b1;
        end
        5'b00000: begin // LOAD
          dcw.reg_wr     = 1'b1;
          dcw.mem_to_reg = 1'b1;
          dcw.alub_src   = 2'b01;
          dcw.mem_op     = ir_f3;
          if (ir_f3 == 3'b011 || ir_f3[2:1] == 2'b11) dill = 1'b1;
        end
        5'b01000: begin // STORE
          dcw.ext_op   = 3'b010;
          dcw.mem_wr   = 1'b1;
          dcw.alub_src = 2'b01;
          dcw.mem_op   = ir_f3;
          if (ir_f3 > 3'b010) dill = 1'b1;
        end
        default: dill = 1'b1;
      endcase
    end
    // Undecodable words never leak partial control into the datapath.
    if (dill) dcw = '0;
  end

  // Sequencer: state, control word, wait counter, sticky flags, retire count
  // and the registered strobes for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      cw         <= '0;
      ir_op      <= '0;
      ir_f3      <= '0;
      ir_f7      <= '0;
      wcnt       <= '0;
      illegal    <= 1'b0;
      timeout    <= 1'b0;
      retired    <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      mem_we_q   <= 1'b0;
      reg_we_q   <= 1'b0;
      pc_we_q    <= 1'b0;
    end else begin
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      mem_we_q   <= 1'b0;
      reg_we_q   <= 1'b0;
      pc_we_q    <= 1'b0;
      case (st)
        S_IDLE: begin
          st         <= S_FETCH;
          imem_req_q <= 1'b1;
          wcnt       <= '0;
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            ir_op <= bus.instr[6:0];
            ir_f3 <= bus.instr[14:12];
            ir_f7 <= bus.instr[31:25];
            st    <= S_DECODE;
          end else if (tmo_hit) begin
            st      <= S_TRAP;
            timeout <= 1'b1;
          end else begin
            imem_req_q <= 1'b1;
            wcnt       <= wcnt + 1'b1;
          end
        end
        S_DECODE: begin
          cw <= dcw;
          if (dill && CHECK_ILLEGAL != 0) begin
            st      <= S_TRAP;
            illegal <= 1'b1;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cw.mem_to_reg || cw.mem_wr) begin
            st         <= S_MEM;
            dmem_req_q <= 1'b1;
            mem_we_q   <= cw.mem_wr;
            wcnt       <= '0;
          end else begin
            st       <= S_WB;
            pc_we_q  <= 1'b1;
            reg_we_q <= cw.reg_wr;
          end
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            st       <= S_WB;
            pc_we_q  <= 1'b1;
            reg_we_q <= cw.reg_wr;
          end else if (tmo_hit) begin
            st      <= S_TRAP;
            timeout <= 1'b1;
          end else begin
            dmem_req_q <= 1'b1;
            mem_we_q   <= cw.mem_wr;
            wcnt       <= wcnt + 1'b1;
          end
        end
        S_WB: begin
          retired    <= retired + 1'b1;
          st         <= S_FETCH;
          imem_req_q <= 1'b1;
          wcnt       <= '0;
        end
        S_TRAP:  st <= S_TRAP;
        default: st <= S_TRAP;
      endcase
    end
  end

  assign state        = st;
  assign bus.imem_req = imem_req_q;
  assign bus.dmem_req = dmem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.ir_we    = (st == S_FETCH) && bus.imem_ack;
  assign reg_we       = reg_we_q;
  assign pc_we        = pc_we_q;

  assign ExtOP    = cw.ext_op;
  assign RegWr    = cw.reg_wr;
  assign Branch   = cw.branch;
  assign MemtoReg = cw.mem_to_reg;
  assign MemWr    = cw.mem_wr;
  assign MemOP    = cw.mem_op;
  assign ALUAsrc  = cw.alua_src;
  assign ALUBsrc  = cw.alub_src;
  assign ALUctr   = cw.alu_ctr;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: table of known encodings, randomized
// instruction stream against a spec-level model, and hand-built sequences
// for timeout, NOP-on-illegal and asynchronous reset corners.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [2:0] ext_op;
    logic       reg_wr;
    logic [2:0] branch;
    logic       mem_to_reg;
    logic       mem_wr;
    logic [2:0] mem_op;
    logic       alua_src;
    logic [1:0] alub_src;
    logic [3:0] alu_ctr;
  } cw_t;

  typedef struct {
    logic [31:0] w;
    int          di;
    int          dd;
    cw_t         cw;
    bit          ill;
  } vec_t;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  bit          sel = 1'b0;
  logic [31:0] instr = '0;
  logic        ia = 1'b0, da = 1'b0;
  int          checks = 0, errors = 0;
  int          exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_control_unit_if m0 ();
  multicycle_control_unit_if m1 ();
  assign m0.instr    = instr;
  assign m1.instr    = instr;
  assign m0.imem_ack = !sel && ia;
  assign m0.dmem_ack = !sel && da;
  assign m1.imem_ack = sel && ia;
  assign m1.dmem_ack = sel && da;

  logic [2:0]  ext0, br0, mop0, st0, ext1, br1, mop1, st1;
  logic        rw0, m2r0, mw0, aa0, rwe0, pwe0, il0, to0;
  logic        rw1, m2r1, mw1, aa1, rwe1, pwe1, il1, to1;
  logic [1:0]  ab0, ab1;
  logic [3:0]  ac0, ac1;
  logic [15:0] ret0, ret1;

  multicycle_control_unit u0 (
    .clk(clk), .rst_n(rst_n), .bus(m0),
    .ExtOP(ext0), .RegWr(rw0), .Branch(br0), .MemtoReg(m2r0), .MemWr(mw0),
    .MemOP(mop0), .ALUAsrc(aa0), .ALUBsrc(ab0), .ALUctr(ac0),
    .reg_we(rwe0), .pc_we(pwe0), .state(st0), .illegal(il0),
    .timeout(to0), .retired(ret0)
  );

  multicycle_control_unit #(.MEM_TIMEOUT(4), .CHECK_ILLEGAL(0), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(m1),
    .ExtOP(ext1), .RegWr(rw1), .Branch(br1), .MemtoReg(m2r1), .MemWr(mw1),
    .MemOP(mop1), .ALUAsrc(aa1), .ALUBsrc(ab1), .ALUctr(ac1),
    .reg_we(rwe1), .pc_we(pwe1), .state(st1), .illegal(il1),
    .timeout(to1), .retired(ret1)
  );

  // Selected DUT view
  logic [2:0]  st;
  logic [5:0]  strb;
  cw_t         cwv;
  logic [1:0]  flags;
  logic [15:0] ret;
  assign st    = sel ? st1 : st0;
  assign strb  = sel ? {m1.imem_req, m1.dmem_req, m1.ir_we, rwe1, m1.mem_we, pwe1}
                     : {m0.imem_req, m0.dmem_req, m0.ir_we, rwe0, m0.mem_we, pwe0};
  assign cwv   = sel ? {ext1, rw1, br1, m2r1, mw1, mop1, aa1, ab1, ac1}
                     : {ext0, rw0, br0, m2r0, mw0, mop0, aa0, ab0, ac0};
  assign flags = sel ? {il1, to1} : {il0, to0};
  assign ret   = sel ? ret1 : ret0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic cw_t mk(input int ext, input int rw, input int br, input int m2r,
                             input int mw, input int mop, input int aa, input int ab,
                             input int ac);
    cw_t c;
    c.ext_op = 3'(ext); c.reg_wr = 1'(rw); c.branch = 3'(br);
    c.mem_to_reg = 1'(m2r); c.mem_wr = 1'(mw); c.mem_op = 3'(mop);
    c.alua_src = 1'(aa); c.alub_src = 2'(ab); c.alu_ctr = 4'(ac);
    return c;
  endfunction

  // Instruction-class view of the decoder: expected control word and legality.
  function automatic void model(input logic [31:0] w, output cw_t c, output bit ill);
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok, isop;
    int alu;
    f3 = w[14:12];
    f7 = w[31:25];
    ok = (w[1:0] == 2'b11);
    c  = '0;
    case (w[6:2])
      5'b01101: c = mk(1, 1, 0, 0, 0, 0, 0, 1, 3);
      5'b00101: c = mk(1, 1, 0, 0, 0, 0, 1, 1, 0);
      5'b00100, 5'b01100: begin
        isop = w[5];
        alu  = (f3 == 3'd3) ? 10 : int'(f3);
        if (f7[5] && (f3 == 3'd5 || (isop && f3 == 3'd0))) alu += 8;
        c = mk(0, 1, 0, 0, 0, 0, 0, isop ? 0 : 1, alu);
        if (isop || f3 inside {3'd1, 3'd5}) begin
          if (!(f7 inside {7'h00, 7'h20})) ok = 0;
          if (f7[5] && !(f3 == 3'd5 || (isop && f3 == 3'd0))) ok = 0;
        end
      end
      5'b11011: c = mk(4, 1, 1, 0, 0, 0, 1, 2, 0);
      5'b11001: begin c = mk(0, 1, 2, 0, 0, 0, 1, 2, 0); if (f3 != 0) ok = 0; end
      5'b11000: begin
        c = mk(3, 0, 4 + 2 * int'(f3[2]) + int'(f3[0]), 0, 0, 0, 0, 0, f3[1] ? 10 : 2);
        if (f3 inside {3'd2, 3'd3}) ok = 0;
      end
      5'b00000: begin
        c = mk(0, 1, 0, 1, 0, int'(f3), 0, 1, 0);
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ok = 0;
      end
      5'b01000: begin
        c = mk(2, 0, 0, 0, 1, int'(f3), 0, 1, 0);
        if (f3 > 3'd2) ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) c = '0;
    ill = !ok;
  endfunction

  // One clock: drive acks at the falling edge, check state and strobes just after.
  task automatic step(input logic [2:0] es, input logic ai, input logic ad,
                      input cw_t e, input string tag);
    logic [5:0] xs;
    @(negedge clk);
    ia = ai; da = ad;
    #1;
    xs = {es == S_FETCH, es == S_MEM, es == S_FETCH && ai,
          es == S_WB && e.reg_wr, es == S_MEM && e.mem_wr, es == S_WB};
    chk({tag, " state/strobes"}, {st, strb}, {es, xs});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ia = 1'b0; da = 1'b0;
    #1;
    chk("reset state/strobes", {st, strb}, 0);
    chk("reset cw", cwv, 0);
    chk("reset retired/flags", {ret, flags}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle after reset", st, S_IDLE);
    exp_ret = 0;
  endtask

  // Executes one instruction from FETCH; di/dd = wait cycles before each ack.
  task automatic run_instr(input logic [31:0] w, input int di, input int dd,
                           input string tag, output cw_t seen);
    cw_t e;
    bit il;
    model(w, e, il);
    instr = w;
    for (int k = 0; k <= di; k++) step(S_FETCH, k == di, rb(), e, tag);
    step(S_DECODE, rb(), rb(), e, tag);
    if (il && !sel) begin
      step(S_TRAP, rb(), rb(), e, tag);
      seen = cwv;
      chk({tag, " trap cw"}, cwv, 0);
      chk({tag, " illegal flag"}, flags, 2'b10);
      step(S_TRAP, 1'b1, 1'b1, e, tag);
      step(S_TRAP, 1'b1, 1'b1, e, tag);
    end else begin
      step(S_EXEC, rb(), rb(), e, tag);
      seen = cwv;
      chk({tag, " cw"}, cwv, e);
      chk({tag, " flags"}, flags, 0);
      if (e.mem_to_reg || e.mem_wr)
        for (int k = 0; k <= dd; k++) step(S_MEM, rb(), k == dd, e, tag);
      step(S_WB, rb(), rb(), e, tag);
      exp_ret++;
      @(posedge clk);
      #1;
      chk({tag, " retired"}, ret, exp_ret & 16'hFFFF);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'b0110111;
      1: w[6:0] = 7'b0010111;
      2, 3: w[6:0] = 7'b0010011;
      4, 5: w[6:0] = 7'b0110011;
      6: w[6:0] = 7'b1101111;
      7: w[6:0] = 7'b1100111;
      8: w[6:0] = 7'b1100011;
      9: w[6:0] = 7'b0000011;
      10: w[6:0] = 7'b0100011;
      default: ;
    endcase
    if ($urandom_range(0, 15) == 0) w[6:0] = 7'($urandom);
    case ($urandom_range(0, 2))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  vec_t tbl [14];
  cw_t  seen, e;
  bit   il;

  initial begin
    tbl[0]  = '{32'h00500093, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 1, 0),  0}; // ADDI
    tbl[1]  = '{32'h0000A103, 1, 3, mk(0, 1, 0, 1, 0, 2, 0, 1, 0),  0}; // LW
    tbl[2]  = '{32'h0020A023, 0, 0, mk(2, 0, 0, 0, 1, 2, 0, 1, 0),  0}; // SW
    tbl[3]  = '{32'h40208033, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 8),  0}; // SUB
    tbl[4]  = '{32'h4010D093, 2, 0, mk(0, 1, 0, 0, 0, 0, 0, 1, 13), 0}; // SRAI
    tbl[5]  = '{32'h0020E063, 0, 0, mk(3, 0, 6, 0, 0, 0, 0, 0, 10), 0}; // BLTU
    tbl[6]  = '{32'h123450B7, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 1, 3),  0}; // LUI
    tbl[7]  = '{32'h00001097, 0, 0, mk(1, 1, 0, 0, 0, 0, 1, 1, 0),  0}; // AUIPC
    tbl[8]  = '{32'h008000EF, 0, 0, mk(4, 1, 1, 0, 0, 0, 1, 2, 0),  0}; // JAL
    tbl[9]  = '{32'h000080E7, 0, 0, mk(0, 1, 2, 0, 0, 0, 1, 2, 0),  0}; // JALR
    tbl[10] = '{32'h00208463, 0, 0, mk(3, 0, 4, 0, 0, 0, 0, 0, 2),  0}; // BEQ
    tbl[11] = '{32'h0020B033, 0, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 10), 0}; // SLTU
    tbl[12] = '{32'h0000C103, 0, 2, mk(0, 1, 0, 1, 0, 4, 0, 1, 0),  0}; // LBU
    tbl[13] = '{32'h0000707F, 0, 0, '0,                             1}; // illegal

    sel = 1'b0;
    do_reset();
    foreach (tbl[i]) begin
      run_instr(tbl[i].w, tbl[i].di, tbl[i].dd, $sformatf("vec%0d", i), seen);
      chk($sformatf("vec%0d table cw", i), seen, tbl[i].cw);
    end
    chk("illegal keeps imem_req low", {st, strb}, {S_TRAP, 6'b0});
    do_reset();

    for (int n = 0; n < 150; n++) begin
      logic [31:0] w;
      w = rand_instr();
      model(w, e, il);
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", n), seen);
      if (il) do_reset();
    end

    // Second instance: MEM_TIMEOUT=4, CHECK_ILLEGAL=0
    sel = 1'b1;
    do_reset();
    run_instr(32'h00500093, 0, 0, "t4 addi", seen);
    run_instr(32'h0000707F, 0, 0, "t4 illegal-as-nop", seen);
    chk("t4 nop cw", seen, 0);
    run_instr(32'h0000A103, 3, 3, "t4 ack-at-deadline", seen);

    model(32'h0000A103, e, il);
    instr = 32'h0000A103;
    step(S_FETCH, 1'b1, 1'b0, e, "t4 mem tmo");
    step(S_DECODE, 1'b0, 1'b0, e, "t4 mem tmo");
    step(S_EXEC, 1'b0, 1'b0, e, "t4 mem tmo");
    for (int k = 0; k < 4; k++) step(S_MEM, rb(), 1'b0, e, "t4 mem tmo");
    step(S_TRAP, 1'b1, 1'b1, e, "t4 mem tmo");
    chk("t4 mem timeout flag", flags, 2'b01);
    chk("t4 retired held", ret, 16'd3);
    chk("t4 cw held in trap", cwv, e);
    step(S_TRAP, 1'b1, 1'b1, e, "t4 trap hold");

    do_reset();
    for (int k = 0; k < 4; k++) step(S_FETCH, 1'b0, rb(), '0, "t4 fetch tmo");
    step(S_TRAP, 1'b1, 1'b1, '0, "t4 fetch tmo");
    chk("t4 fetch timeout flag", flags, 2'b01);

    do_reset();
    run_instr(32'h00500093, 0, 0, "t4 pre-reset addi", seen);
    model(32'h0020A023, e, il);
    instr = 32'h0020A023;
    step(S_FETCH, 1'b1, 1'b0, e, "t4 mid-mem");
    step(S_DECODE, 1'b0, 1'b0, e, "t4 mid-mem");
    step(S_EXEC, 1'b0, 1'b0, e, "t4 mid-mem");
    step(S_MEM, 1'b0, 1'b0, e, "t4 mid-mem");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset state/strobes", {st, strb}, 0);
    chk("async reset cw", cwv, 0);
    chk("async reset retired/flags", {ret, flags}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
